pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards between ID and EX.

---
 rtl/pipeline_hazard_ctrl_if.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 57 +++++
 tb/tb_pipeline_hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side hazard inputs and stall/flush controls with perf counters
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             branch_cond;
  logic             ctr_clr;
  logic             hazard;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_valid, ex_is_load, ex_rd, branch_cond, ctr_clr,
    input  hazard, id_ex_bubble, flush_if_id, flush_id_ex, stall_count, flush_count
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_valid, ex_is_load, ex_rd, branch_cond, ctr_clr,
    output hazard, id_ex_bubble, flush_if_id, flush_id_ex, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall / taken-branch flush sequencer with saturating perf counters
module pipeline_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int REG_W        = 5
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             load_use, in_run, br, lu_start, hold;
  always_comb begin
    load_use = bus.ex_valid & bus.ex_is_load & bus.id_valid & (bus.ex_rd != '0)
             & ((bus.ex_rd == bus.id_rs1) | (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));
    in_run   = state_q == RUN;
    // a taken branch overrides whatever the FSM is doing, in every state
    br       = ~reset & bus.branch_cond;
    lu_start = ~reset & ~br & in_run & load_use;
    hold     = lu_start | (~reset & ~br & (state_q == STALL));
    state_d  = br ? ((FLUSH_CYCLES == 1) ? RUN : FLUSH)
             : lu_start ? ((STALL_CYCLES == 1) ? RUN : STALL)
             : (!in_run && cnt_q == CW'(1)) ? RUN : state_q;
    cnt_d    = br ? CW'(FLUSH_CYCLES - 1)
             : lu_start ? CW'(STALL_CYCLES - 1)
             : !in_run ? cnt_q - CW'(1) : cnt_q;
    stall_d  = bus.ctr_clr ? '0 : (hold && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d  = bus.ctr_clr ? '0 : (br && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign bus.hazard       = hold;
  assign bus.id_ex_bubble = hold;
  assign bus.flush_id_ex  = br;
  assign bus.flush_if_id  = br | (~reset & (state_q == FLUSH));
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks on a default instance and a STALL=3/FLUSH=2/CNT_W=4 instance
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_uses_rs2 = 0, ex_valid = 0, ex_is_load = 0, branch_cond = 0, ctr_clr = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  int total = 0, passed = 0;
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) a_if ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  b_if ();
  pipeline_hazard_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16), .REG_W(5))
    u_a (.clk(clk), .reset(reset), .bus(a_if));
  pipeline_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4), .REG_W(5))
    u_b (.clk(clk), .reset(reset), .bus(b_if));
  assign {a_if.id_valid, a_if.id_uses_rs2, a_if.ex_valid, a_if.ex_is_load, a_if.branch_cond, a_if.ctr_clr}
       = {id_valid, id_uses_rs2, ex_valid, ex_is_load, branch_cond, ctr_clr};
  assign {b_if.id_valid, b_if.id_uses_rs2, b_if.ex_valid, b_if.ex_is_load, b_if.branch_cond, b_if.ctr_clr}
       = {id_valid, id_uses_rs2, ex_valid, ex_is_load, branch_cond, ctr_clr};
  assign {a_if.id_rs1, a_if.id_rs2, a_if.ex_rd} = {id_rs1, id_rs2, ex_rd};
  assign {b_if.id_rs1, b_if.id_rs2, b_if.ex_rd} = {id_rs1, id_rs2, ex_rd};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic lu(input logic on);
    {ex_valid, ex_is_load, id_valid} = {3{on}};
    ex_rd  = on ? 5'd5 : 5'd0;
    id_rs1 = on ? 5'd5 : 5'd0;
    id_rs2 = 5'd0;
    id_uses_rs2 = 1'b0;
  endtask
  initial begin
    repeat (2) edge1();
    reset = 0;
    #1;
    check("rst_hazard", a_if.hazard, 0);
    check("rst_flush", {a_if.flush_if_id, a_if.flush_id_ex, b_if.flush_if_id}, 0);
    check("rst_cnt", {a_if.stall_count, b_if.flush_count}, 0);
    lu(1);
    #1;
    check("lu_a", {a_if.hazard, a_if.id_ex_bubble}, 2'b11);
    check("lu_b", {b_if.hazard, b_if.id_ex_bubble}, 2'b11);
    edge1();
    lu(0);
    #1;
    check("lu_a_done", a_if.hazard, 0);
    check("lu_a_cnt", a_if.stall_count, 1);
    check("lu_b_c2", b_if.hazard, 1);
    edge1();
    check("lu_b_c3", b_if.hazard, 1);
    edge1();
    check("lu_b_end", b_if.hazard, 0);
    check("lu_b_cnt", b_if.stall_count, 3);
    {ex_valid, ex_is_load, id_valid} = 3'b111;
    {ex_rd, id_rs1} = {5'd0, 5'd0};
    #1;
    check("rd_x0", a_if.hazard, 0);
    {ex_rd, id_rs1, id_rs2, id_uses_rs2} = {5'd7, 5'd3, 5'd7, 1'b0};
    #1;
    check("rs2_unused", {a_if.hazard, b_if.hazard}, 0);
    id_uses_rs2 = 1;
    #1;
    check("rs2_used", {a_if.hazard, b_if.hazard}, 2'b11);
    ex_valid = 0;
    #1;
    check("ex_invalid", a_if.hazard, 0);
    lu(0);
    ctr_clr = 1;
    edge1();
    ctr_clr = 0;
    check("clr", {a_if.stall_count, b_if.stall_count}, 0);
    lu(1);
    branch_cond = 1;
    #1;
    check("br_lu_a", {a_if.flush_if_id, a_if.flush_id_ex, a_if.hazard, a_if.id_ex_bubble}, 4'b1100);
    check("br_lu_b", {b_if.flush_if_id, b_if.flush_id_ex, b_if.hazard}, 3'b110);
    edge1();
    branch_cond = 0;
    #1;
    check("br_cnt_a", {a_if.flush_count, a_if.stall_count}, {16'd1, 16'd0});
    check("fl_b_lu_ignored", {b_if.flush_if_id, b_if.flush_id_ex, b_if.hazard}, 3'b100);
    lu(0);
    branch_cond = 1;
    #1;
    check("fl_b_rebr", {b_if.flush_if_id, b_if.flush_id_ex}, 2'b11);
    edge1();
    branch_cond = 0;
    #1;
    check("fl_b_cnt", b_if.flush_count, 2);
    check("fl_b_restart", {b_if.flush_if_id, b_if.flush_id_ex}, 2'b10);
    check("fl_a_cnt", a_if.flush_count, 2);
    edge1();
    check("fl_b_end", b_if.flush_if_id, 0);
    lu(1);
    repeat (20) edge1();
    check("sat_b", b_if.stall_count, 15);
    check("nosat_a", a_if.stall_count, 20);
    ctr_clr = 1;
    #1;
    check("clr_hz", b_if.hazard, 1);
    edge1();
    ctr_clr = 0;
    check("clr_win", {a_if.stall_count, b_if.stall_count}, 0);
    lu(0);
    repeat (3) edge1();
    lu(1);
    edge1();
    lu(0);
    #1;
    check("mid_stall", b_if.hazard, 1);
    reset = 1;
    branch_cond = 1;
    #1;
    check("async_out", {b_if.hazard, b_if.id_ex_bubble, b_if.flush_if_id, b_if.flush_id_ex, a_if.flush_id_ex}, 0);
    check("async_cnt", {b_if.stall_count, b_if.flush_count, a_if.flush_count}, 0);
    branch_cond = 0;
    #1;
    reset = 0;
    #1;
    check("rel_run", b_if.hazard, 0);
    edge1();
    check("rel_stay", {b_if.hazard, b_if.stall_count}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
